// File: rtl/jk_drv_pkg.sv
// Shared state encoding and JK excitation table for the JK flip-flop sequence driver.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    VERIFY = 2'd2
  } jk_state_e;

  // Returns {J,K}; don't-cares resolved to 0 so J=K=1 is never produced.
  function automatic logic [1:0] excite(input logic q, input logic tgt);
    return {~q & tgt, q & ~tgt};
  endfunction

endpackage

// File: rtl/jk_bit_fifo.sv
// 1-bit wide target FIFO with extra-MSB pointers for full/empty; head is visible
// only after the push edge, so there is no fall-through.
module jk_bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_bit;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives J/K so a downstream JK flop steps through a stream of target bits.
// Define JK_DRV_CHECK_EN to build the post-transition Q check (err / err_cnt).
module jk_excite_driver
  import jk_drv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] done_cnt
);

  jk_state_e        state_q, state_d;
  logic             j_q, j_d, k_q, k_d;
  logic             exp_q, exp_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic             fifo_head, fifo_full, fifo_empty;
  logic             pop, load;

  jk_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tgt_valid && !fifo_full),
    .push_bit (tgt_bit),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign tgt_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign J         = j_q;
  assign K         = k_q;
  assign done_cnt  = done_cnt_q;

`ifdef JK_DRV_CHECK_EN
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

  always_comb begin
    state_d    = state_q;
    j_d        = 1'b0;
    k_d        = 1'b0;
    exp_d      = exp_q;
    done_cnt_d = done_cnt_q;
    pop        = 1'b0;
    load       = 1'b0;
`ifdef JK_DRV_CHECK_EN
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
`endif
    case (state_q)
      IDLE:   load = !fifo_empty;
      APPLY:  state_d = VERIFY;
      VERIFY: begin
        done_cnt_d = done_cnt_q + CNT_W'(1);
`ifdef JK_DRV_CHECK_EN
        if (q_fb != exp_q) begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
`endif
        load = !fifo_empty;
        if (!load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Excitation is taken from the flop's actual Q at the pop edge.
    if (load) begin
      pop        = 1'b1;
      {j_d, k_d} = excite(q_fb, fifo_head);
      exp_d      = fifo_head;
      state_d    = APPLY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      exp_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      k_q        <= k_d;
      exp_q      <= exp_d;
      done_cnt_q <= done_cnt_d;
    end
  end

`ifdef JK_DRV_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: doc/jk_excite_driver.md
# jk_excite_driver

Sequence driver for the JK flip-flop interface: accepts a stream of target state bits over a valid/ready handshake, buffers them, and generates the J/K excitation that moves a downstream JK flip-flop to each target in turn. It reads the flop's Q back, so it can compute each excitation from the actual current state and optionally check that each transition landed. It sits on the drive side of any JK-flop-based register or counter slice.

## Interface
- DEPTH, 4: target FIFO depth; power of 2, at least 2.
- CNT_W, 8: width of the transition and error counters.

- Clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- tgt_valid  in  1  a target bit is offered.
- tgt_bit  in  1  the desired next Q.
- tgt_ready  out  1  the FIFO can accept a bit; equals !full.
- q_fb  in  1  Q fed back from the driven JK flip-flop.
- J  out  1  registered J drive.
- K  out  1  registered K drive.
- busy  out  1  state != IDLE, or the FIFO is non-empty.
- err  out  1  sticky mismatch flag.
- err_cnt  out  CNT_W  count of mismatches; saturates at all-ones.
- done_cnt  out  CNT_W  count of completed transitions; wraps modulo 2^CNT_W.

## Operation
- **Reset:** J=0, K=0, err=0, err_cnt=0, done_cnt=0, FIFO empty, tgt_ready=1, busy=0, state IDLE.
- **Push:** a bit is accepted on an edge where tgt_valid && tgt_ready.
- **No fall-through:** a bit pushed into an empty FIFO is first poppable on the following edge.
- **Excitation**, using Q = q_fb sampled at the pop edge, target T:
  - Q=0, T=0 → J=0, K=0
  - Q=0, T=1 → J=1, K=0
  - Q=1, T=0 → J=0, K=1
  - Q=1, T=1 → J=0, K=0
  - Don't-cares are fixed at 0; J=K=1 is never driven.
- **FSM** (one transition per edge):
  - IDLE: J=K=0. If FIFO non-empty → pop, register J/K = excite(q_fb, head), exp <= head, go to APPLY.
  - APPLY: J/K are held for this cycle, and the JK flop captures them at the closing edge. On that same edge: J/K <= 0,0, go to VERIFY.
  - VERIFY: q_fb now shows the new Q. At the closing edge:
    - done_cnt++.
    - If checking is enabled and q_fb != exp: err <= 1, and err_cnt++ unless it is already all-ones.
    - If the FIFO is non-empty → pop and go to APPLY, same as the IDLE pop; otherwise → IDLE.
- **Full FIFO:** tgt_ready=0 and pushes are refused, including on an edge where a pop occurs. Ready rises on the cycle after the pop.
- **Reset mid-operation:** all state clears immediately, including any in-flight bit. J/K drop to 0 asynchronously.

## Timing
- **Latency:** a target popped at edge e gives J/K valid in cycle e..e+1. The flop updates at e+1, and the result is checked at e+2.
- **Throughput:** one target per 2 cycles when the FIFO stays non-empty. Pushes run at up to 1 per cycle until full.
- **Outputs:** J, K, err, err_cnt and done_cnt are registered. tgt_ready and busy are combinational from registers only.
- **Feedback path:** q_fb must be a registered flop output, so there is no combinational loop.

## Configuration
- **JK_DRV_CHECK_EN defined:** the exp-vs-q_fb comparison is built, and err and err_cnt are live.
- **JK_DRV_CHECK_EN undefined:** err and err_cnt are tied to 0.
  - The VERIFY state is still present, so latency, throughput and done_cnt are unchanged.

## Structure
- **Package jk_drv_pkg:**
  - state encoding: IDLE=2'd0, APPLY=2'd1, VERIFY=2'd2.
  - excite function returning {J,K} from (q, target).
- **Sub-module jk_bit_fifo:** 1-bit wide, DEPTH entries, with push/pop/full/empty and its own async active-high rst. Pointers are one bit wider than log2(DEPTH) for the full/empty distinction.
- **Bench:** q_fb is driven by a JK flip-flop built from a D flip-flop. It uses its own active-low reset, held deasserted after start-up.

## Test plan
1. **Basic sequence.** Stimulus: reset, Q=0, push 1,0,1,1. Required response:
   - APPLY-cycle J/K: (1,0), (0,1), (1,0), (0,0).
   - Final Q=1, done_cnt=4, err=0, busy=0 after the last VERIFY.
2. **Back-pressure.** Stimulus: hold tgt_valid=1 and stream 6 bits with DEPTH=4. Required response:
   - tgt_ready drops while full.
   - All 6 bits are accepted in order, done_cnt=6, and Q matches each target.
3. **Fault detection** (macro defined). Stimulus: force q_fb=0, push 1,1. Required response:
   - err=1 after the first VERIFY edge.
   - err_cnt=2 at the end.
   - Both APPLY cycles show J/K=(1,0).
4. **Counter limits.** Stimulus: CNT_W=2, q_fb stuck at 0, push 1 five times. Required response: err_cnt=3 (saturated) and done_cnt=1 (wrapped).
5. **Reset mid-operation.** Stimulus: assert rst during APPLY. Required response:
   - J=K=0 immediately, FIFO empty, counters 0.
   - After release, pushing 1 is handled normally.
6. **Checking compiled out** (macro undefined). Stimulus: repeat scenario 3. Required response: err=0, err_cnt=0, done_cnt=2.
